// File: rtl/machine_timer_pkg.sv
// machine_timer_pkg: register word offsets, CTRL bit indices, bus FSM states and byte-lane merge
package machine_timer_pkg;
    localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TIMER_CTRL        = 3'd4;
    localparam logic [2:0] TIMER_PRESCALE    = 3'd5;
    localparam logic [2:0] TIMER_STATUS      = 3'd6;
    localparam logic [2:0] TIMER_PERIOD      = 3'd7;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_RELOAD = 2;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] be);
        return {be[3] ? wdata[31:24] : old[31:24], be[2] ? wdata[23:16] : old[23:16],
                be[1] ? wdata[15:8] : old[15:8], be[0] ? wdata[7:0] : old[7:0]};
    endfunction
endpackage

// File: rtl/machine_timer_prescaler.sv
// machine_timer_prescaler: divider emitting one tick every PRESCALE+1 enabled cycles
module machine_timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);
    logic [PRESCALE_WIDTH-1:0] count;
    assign tick = en && count == prescale;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr || tick) count <= '0;
        else if (en) count <= count + 1'b1;
endmodule

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped 64-bit mtime/mtimecmp timer with prescaler and level interrupt.
// Define MACHINE_TIMER_RELOAD_EN to add PERIOD at 0x1C and CTRL.RELOAD periodic re-arm.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          PRESCALE_WIDTH = 16,
    parameter int unsigned RESET_PRESCALE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            we_i,
    output logic [31:0]           rdata_o,
    output logic                  irq_o
);
    logic [0:0] state;
    logic [63:0] mtime, mtimecmp;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [31:0] shadow, rdata_q, cur, wv, ctrl_word, period_word;
    logic [31:0] regs [8];
    logic [2:0] off;
    logic en, irq_en, pending, irq_q, tick, match, accept, wr, rd, clr_pend;
    logic unused;
    assign unused = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};
    assign off = addr_i[4:2];
    assign accept = state == ST_IDLE && valid_i;
    assign wr = accept && we_i != 4'b0;
    assign rd = accept && we_i == 4'b0;
    assign clr_pend = wr && off == TIMER_STATUS && we_i[0] && wdata_i[0];
    assign match = en && mtime >= mtimecmp;
    assign ready_o = state == ST_RESP;
    assign rdata_o = ready_o ? rdata_q : '0;
    assign irq_o = irq_q;
`ifdef MACHINE_TIMER_RELOAD_EN
    logic reload;
    logic [31:0] period;
    assign ctrl_word = {29'b0, reload, irq_en, en};
    assign period_word = period;
`else
    assign ctrl_word = {30'b0, irq_en, en};
    assign period_word = '0;
`endif
    // Index order follows the word offsets in the package
    assign regs = '{mtime[31:0], mtime[63:32], mtimecmp[31:0], mtimecmp[63:32],
                    ctrl_word, 32'(prescale), {31'b0, pending}, period_word};
    assign cur = regs[off];
    assign wv = byte_merge(cur, wdata_i, we_i);

    machine_timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk(clk),
        .rst(rst),
        .en(en),
        .clr(wr && off == TIMER_PRESCALE),
        .prescale(prescale),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= ST_IDLE;
            rdata_q  <= '0;
            shadow   <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= PRESCALE_WIDTH'(RESET_PRESCALE);
            pending  <= 1'b0;
            irq_q    <= 1'b0;
`ifdef MACHINE_TIMER_RELOAD_EN
            reload   <= 1'b0;
            period   <= '0;
`endif
        end else begin
            state <= accept ? ST_RESP : ST_IDLE;
            if (accept) rdata_q <= wr ? '0 : off == TIMER_MTIME_HI ? shadow : cur;
            if (rd && off == TIMER_MTIME_LO) shadow <= mtime[63:32];
            // A bus write to mtime swallows a coincident tick
            if (wr && off == TIMER_MTIME_LO) mtime[31:0] <= wv;
            else if (wr && off == TIMER_MTIME_HI) mtime[63:32] <= wv;
            else if (tick) mtime <= mtime + 64'd1;
            if (wr && off == TIMER_MTIMECMP_LO) mtimecmp[31:0] <= wv;
            else if (wr && off == TIMER_MTIMECMP_HI) mtimecmp[63:32] <= wv;
`ifdef MACHINE_TIMER_RELOAD_EN
            else if (match && !pending && reload) mtimecmp <= mtimecmp + {32'b0, period};
            if (wr && off == TIMER_CTRL) reload <= wv[CTRL_RELOAD];
            if (wr && off == TIMER_PERIOD) period <= wv;
`endif
            if (wr && off == TIMER_CTRL) begin
                en     <= wv[CTRL_EN];
                irq_en <= wv[CTRL_IRQ_EN];
            end
            if (wr && off == TIMER_PRESCALE) prescale <= wv[PRESCALE_WIDTH-1:0];
            pending <= match || (pending && !clr_pend);
            irq_q <= pending && irq_en;
        end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: random and directed bus traffic against an arithmetic timer model;
// expected read data is queued at acceptance and checked by a monitor when ready_o rises.
module tb_machine_timer;
    logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0;
    logic ready_o, irq_o;
    logic [31:0] addr_i = '0, wdata_i = '0, rdata_o;
    logic [3:0] we_i = '0;
    int checks = 0, passes = 0;
    logic [31:0] exp_q[$];
    logic [63:0] m_base, c_base, n_en, pre, cmp;
    logic [31:0] m_shadow;
    logic m_en, m_ien, m_pend, m_irq, m_busy;

    machine_timer dut (
        .clk(clk),
        .rst(rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .we_i(we_i),
        .rdata_o(rdata_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_base = '0; c_base = '0; n_en = '0; pre = '0; cmp = '1; m_shadow = '0;
        m_en = 0; m_ien = 0; m_pend = 0; m_irq = 0; m_busy = 0;
        exp_q.delete();
    endfunction

    // mtime advances once per (prescale+1) enabled cycles counted from the last rebase point
    function automatic logic [63:0] cur_mtime();
        return m_base + (c_base + n_en) / (pre + 64'd1);
    endfunction

    task automatic cycle(logic v, logic [31:0] a, logic [3:0] w, logic [31:0] d);
        logic [63:0] mt, cnt, mt_n, cnt_n;
        logic [31:0] r, t;
        logic [2:0] off;
        logic acc, wr, rd, tk, mat;
        valid_i = v; addr_i = a; we_i = w; wdata_i = d;
        acc = v && !m_busy; wr = acc && w != 0; rd = acc && w == 0; off = a[4:2];
        mt = cur_mtime();
        cnt = (c_base + n_en) % (pre + 64'd1);
        tk = m_en && cnt == pre;
        mat = m_en && mt >= cmp;
        case (off)
            3'd0: r = mt[31:0];
            3'd1: r = m_shadow;
            3'd2: r = cmp[31:0];
            3'd3: r = cmp[63:32];
            3'd4: r = {30'b0, m_ien, m_en};
            3'd5: r = {16'b0, pre[15:0]};
            3'd6: r = {31'b0, m_pend};
            default: r = '0;
        endcase
        if (acc) exp_q.push_back(wr ? 32'h0 : r);
        @(posedge clk);
        m_irq = m_pend && m_ien;
        m_pend = mat ? 1'b1 : (wr && off == 3'd6 && w[0] && d[0]) ? 1'b0 : m_pend;
        if (rd && off == 3'd0) m_shadow = mt[63:32];
        cnt_n = (wr && off == 3'd5) ? 64'd0 : tk ? 64'd0 : m_en ? cnt + 64'd1 : cnt;
        mt_n = mt + {63'b0, tk};
        if (wr) begin
            case (off)
                3'd0: mt_n = {mt[63:32], merge(mt[31:0], d, w)};
                3'd1: mt_n = {merge(mt[63:32], d, w), mt[31:0]};
                3'd2: cmp[31:0] = merge(cmp[31:0], d, w);
                3'd3: cmp[63:32] = merge(cmp[63:32], d, w);
                3'd4: begin t = merge({30'b0, m_ien, m_en}, d, w); m_en = t[0]; m_ien = t[1]; end
                3'd5: begin t = merge({16'b0, pre[15:0]}, d, w); pre = {48'b0, t[15:0]}; end
                default: ;
            endcase
            m_base = mt_n; c_base = cnt_n; n_en = '0;
        end else if (m_en) n_en++;
        m_busy = acc;
        @(negedge clk);
    endtask

    task automatic access(logic [31:0] a, logic [3:0] w, logic [31:0] d);
        cycle(1'b1, a, w, d);
        cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, $urandom, 4'($urandom), $urandom);
    endtask

    task automatic mid_reset();
        valid_i = 1; addr_i = 32'h10; we_i = 4'h1; wdata_i = 32'h3;
        @(posedge clk);
        #1 rst = 1; valid_i = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
    endtask

    always @(negedge clk) if (!rst) begin
        check("ready", {31'b0, ready_o}, {31'b0, m_busy});
        if (ready_o && exp_q.size() > 0) check("rdata", rdata_o, exp_q.pop_front());
        else if (!ready_o) check("rdata_idle", rdata_o, 32'h0);
        check("irq", {31'b0, irq_o}, {31'b0, m_irq});
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0] w;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
        for (int i = 0; i < 8; i++) access(32'(i * 4), 4'h0, 32'h0);
        access(32'h14, 4'hF, 32'd3);
        access(32'h10, 4'hF, 32'h1);
        idle(40);
        access(32'h00, 4'h0, 0);
        access(32'h10, 4'hF, 32'h0);
        idle(10);
        access(32'h00, 4'h0, 0);
        access(32'h00, 4'hF, 32'hFFFF_FFFF);
        access(32'h04, 4'hF, 32'h0);
        access(32'h14, 4'hF, 32'h0);
        access(32'h10, 4'h1, 32'h1);
        idle(3);
        access(32'h00, 4'h0, 0);
        access(32'h04, 4'h0, 0);
        idle(5);
        access(32'h04, 4'h0, 0);
        access(32'h10, 4'hF, 32'h0);
        access(32'h00, 4'hF, 32'h0);
        access(32'h04, 4'hF, 32'h0);
        access(32'h08, 4'hF, 32'd20);
        access(32'h0C, 4'hF, 32'h0);
        access(32'h10, 4'hF, 32'h3);
        idle(30);
        access(32'h18, 4'hF, 32'h1);
        idle(5);
        access(32'h08, 4'hF, 32'd1000);
        access(32'h18, 4'hF, 32'h1);
        idle(5);
        access(32'h14, 4'b0010, 32'hAABB_CCDD);
        access(32'h14, 4'h0, 0);
        access(32'h20, 4'h0, 0);
        access(32'h1C, 4'hF, 32'h1234_5678);
        access(32'h1C, 4'h0, 0);
        mid_reset();
        access(32'h10, 4'h0, 0);
        for (int k = 0; k < 300; k++) begin
            a = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 5);
            w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            d = a[4:2] == 3'd5 ? 32'($urandom_range(0, 3)) :
                a[4:2] == 3'd3 ? 32'($urandom_range(0, 1)) : $urandom;
            if (a[4:2] == 3'd2 && $urandom_range(0, 1)) d = 32'($urandom_range(0, 400));
            access(a, w, d);
            idle($urandom_range(0, 3));
        end
        idle(3);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL pending_responses: got %0d outstanding required 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
